// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: board reset to per-domain synchronous resets.
// All domain resets assert together and release one at a time in ascending
// order with a fixed gap; a software reset can be requested with a 4-phase
// req/ack handshake once the release sequence has completed.
module rst_seq_ctrl #(
  parameter int N_DOM       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STAGE_DELAY = 16,
  parameter int HOLD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_req_i,
  output logic             sw_ack_o,
  output logic [N_DOM-1:0] rst_o,
  output logic             rst_done_o,
  output logic             busy_o
);

  localparam int CNT_MAX_I = (STAGE_DELAY > HOLD_CYCLES) ? STAGE_DELAY : HOLD_CYCLES;
  localparam int CW        = $clog2(CNT_MAX_I) + 1;
  localparam int DW        = $clog2(N_DOM) + 1;
  localparam int SW        = SYNC_STAGES - 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(CNT_MAX_I);
  localparam logic [CW-1:0] STAGE_END = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DOM_LAST  = DW'(N_DOM - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_RELEASE,
    S_DONE,
    S_HOLD,
    S_ACK
  } state_t;

  state_t        state;
  logic [SW-1:0] sync_q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dom;
  logic          rst_released;

  // The FSM's RESET state acts as the last synchroniser stage, so only
  // SYNC_STAGES-1 flops are needed here to exit RESET on edge SYNC_STAGES.
  assign rst_released = sync_q[SW-1];

  // Deassertion synchroniser: clears asynchronously, fills with ones on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | SW'(1);
    end
  end

  // Sequencer FSM; every output is registered here so nothing can glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RESET;
      cnt        <= '0;
      dom        <= '0;
      rst_o      <= '1;
      sw_ack_o   <= 1'b0;
      rst_done_o <= 1'b0;
      busy_o     <= 1'b1;
    end else begin
      case (state)
        S_RESET: begin
          cnt <= '0;
          dom <= '0;
          if (rst_released) begin
            state <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          sw_ack_o <= 1'b0;
          if (cnt == STAGE_END) begin
            cnt <= '0;
            for (int i = 0; i < N_DOM; i++) begin
              if (dom == DW'(i)) begin
                rst_o[i] <= 1'b0;
              end
            end
            if (dom == DOM_LAST) begin
              state      <= S_DONE;
              rst_done_o <= 1'b1;
              busy_o     <= 1'b0;
            end else begin
              dom <= dom + 1'b1;
            end
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
        end

        S_DONE: begin
          cnt <= '0;
          dom <= '0;
          if (sw_req_i) begin
            state      <= S_HOLD;
            rst_o      <= '1;
            rst_done_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt == HOLD_END) begin
            cnt      <= '0;
            dom      <= '0;
            sw_ack_o <= 1'b1;
            // A request already withdrawn still gets its one-cycle ack,
            // and release starts counting from this same edge.
            state    <= sw_req_i ? S_ACK : S_RELEASE;
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
        end

        S_ACK: begin
          cnt <= '0;
          dom <= '0;
          if (!sw_req_i) begin
            sw_ack_o <= 1'b0;
            state    <= S_RELEASE;
          end
        end

        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: table-driven, directed and randomized checks of the
// reset sequencer against an edge-count based reference model.
module tb_rst_seq_ctrl;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int SD = 16;
  localparam int H  = 8;

  localparam int MODE_REL  = 0;
  localparam int MODE_IDLE = 1;
  localparam int MODE_HOLD = 2;
  localparam int MODE_ACK  = 3;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       sw_req  = 1'b0;
  logic       sw_req2 = 1'b0;
  logic       sw_ack;
  logic       rst_done;
  logic       busy;
  logic [3:0] rst_vec;
  logic       sw_ack2;
  logic       rst_done2;
  logic       busy2;
  logic [0:0] rst_vec2;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state: t counts posedges since rst fell
  int   t;
  int   mode;
  int   origin;
  int   hs;
  logic m_ack;

  typedef struct {
    int         edge_n;
    logic       req;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[19];

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .N_DOM(N), .SYNC_STAGES(SS), .STAGE_DELAY(SD), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst(rst), .sw_req_i(sw_req), .sw_ack_o(sw_ack),
    .rst_o(rst_vec), .rst_done_o(rst_done), .busy_o(busy)
  );

  rst_seq_ctrl #(
    .N_DOM(1), .SYNC_STAGES(3), .STAGE_DELAY(1), .HOLD_CYCLES(8)
  ) dut_small (
    .clk(clk), .rst(rst), .sw_req_i(sw_req2), .sw_ack_o(sw_ack2),
    .rst_o(rst_vec2), .rst_done_o(rst_done2), .busy_o(busy2)
  );

  function automatic int cleared_at(input int tt);
    int c;
    if (tt <= origin) return 0;
    c = (tt - origin) / SD;
    if (c > N) c = N;
    return c;
  endfunction

  function automatic logic [6:0] model_out();
    logic [3:0] r;
    logic       done;
    r = 4'hF;
    case (mode)
      MODE_REL:  r = 4'hF << cleared_at(t);
      MODE_IDLE: r = 4'h0;
      default:   r = 4'hF;
    endcase
    done = (mode == MODE_IDLE);
    return {r, m_ack, done, ~done};
  endfunction

  function automatic logic [6:0] dut_out();
    return {rst_vec, sw_ack, rst_done, busy};
  endfunction

  task automatic modelReset();
    t      = 0;
    mode   = MODE_REL;
    origin = SS;
    hs     = 0;
    m_ack  = 1'b0;
  endtask

  task automatic modelStep();
    t = t + 1;
    case (mode)
      MODE_REL: begin
        m_ack = 1'b0;
        if (cleared_at(t) == N) mode = MODE_IDLE;
      end
      MODE_IDLE: begin
        if (sw_req) begin
          mode = MODE_HOLD;
          hs   = t;
        end
      end
      MODE_HOLD: begin
        if (t == hs + H) begin
          m_ack = 1'b1;
          if (sw_req) begin
            mode = MODE_ACK;
          end else begin
            mode   = MODE_REL;
            origin = t;
          end
        end
      end
      default: begin
        if (!sw_req) begin
          m_ack  = 1'b0;
          mode   = MODE_REL;
          origin = t;
        end
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [6:0] actual,
                             input logic [6:0] expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, t, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic q);
    rst    = r;
    sw_req = q;
    if (r) modelReset();
  endtask

  task automatic stepEdge();
    @(posedge clk);
    if (!rst) modelStep();
    @(negedge clk);
    checkOutput("model", dut_out(), model_out());
    if (t <= 12) begin
      checkOutput("small_dut", {3'b000, rst_vec2, sw_ack2, rst_done2, busy2},
                  (t < 4) ? 7'b0001001 : 7'b0000010);
    end
  endtask

  task automatic runTo(input int target);
    int guard;
    guard = 0;
    while (t < target && guard < 1000) begin
      stepEdge();
      guard = guard + 1;
    end
    if (t < target) begin
      tests_run    = tests_run + 1;
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL run_to: reached edge %0d, expected edge %0d", t, target);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at edge %0d", t);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rst_left;

    vecs = '{
      '{17,  1'b0, 7'b1111001}, '{18,  1'b0, 7'b1110001},
      '{33,  1'b0, 7'b1110001}, '{34,  1'b0, 7'b1100001},
      '{50,  1'b0, 7'b1000001}, '{65,  1'b0, 7'b1000001},
      '{66,  1'b0, 7'b0000010}, '{99,  1'b0, 7'b0000010},
      '{100, 1'b1, 7'b1111001}, '{107, 1'b1, 7'b1111001},
      '{108, 1'b1, 7'b1111101}, '{119, 1'b1, 7'b1111101},
      '{120, 1'b0, 7'b1111001}, '{135, 1'b0, 7'b1111001},
      '{136, 1'b0, 7'b1110001}, '{152, 1'b0, 7'b1100001},
      '{168, 1'b0, 7'b1000001}, '{183, 1'b0, 7'b1000001},
      '{184, 1'b0, 7'b0000010}
    };

    // power-on reset held for 5 cycles
    modelReset();
    repeat (5) stepEdge();
    checkOutput("reset_state", dut_out(), 7'b1111001);
    applyStimulus(1'b0, 1'b0);

    // power-on release followed by a full software reset handshake
    for (int i = 0; i < 19; i++) begin
      runTo(vecs[i].edge_n - 1);
      sw_req = vecs[i].req;
      stepEdge();
      checkOutput($sformatf("vec%0d_e%0d", i, vecs[i].edge_n), dut_out(), vecs[i].exp);
    end

    // single-cycle request: hold still completes, one-cycle ack
    runTo(199);
    sw_req = 1'b1;
    stepEdge();
    checkOutput("short_req_e200", dut_out(), 7'b1111001);
    sw_req = 1'b0;
    runTo(207);
    checkOutput("short_req_e207", dut_out(), 7'b1111001);
    stepEdge();
    checkOutput("short_req_ack_e208", dut_out(), 7'b1111101);
    stepEdge();
    checkOutput("short_req_ack_off_e209", dut_out(), 7'b1111001);
    runTo(223);
    checkOutput("short_req_e223", dut_out(), 7'b1111001);
    stepEdge();
    checkOutput("short_req_rel0_e224", dut_out(), 7'b1110001);

    // asynchronous reset in the middle of a release
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("async_rst_mid", dut_out(), 7'b1111001);
    repeat (5) stepEdge();
    applyStimulus(1'b0, 1'b0);

    // early request held from edge 10 is serviced after release completes
    runTo(9);
    sw_req = 1'b1;
    runTo(65);
    checkOutput("early_req_e65", dut_out(), 7'b1000001);
    stepEdge();
    checkOutput("early_req_done_e66", dut_out(), 7'b0000010);
    stepEdge();
    checkOutput("early_req_hold_e67", dut_out(), 7'b1111001);
    runTo(74);
    checkOutput("early_req_e74", dut_out(), 7'b1111001);
    stepEdge();
    checkOutput("early_req_ack_e75", dut_out(), 7'b1111101);
    runTo(77);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("rst_in_ack", dut_out(), 7'b1111001);
    repeat (3) stepEdge();
    applyStimulus(1'b0, 1'b0);

    // reset at edge 40 of a release, deasserted at edge 45
    runTo(40);
    checkOutput("mid_release_e40", dut_out(), 7'b1100001);
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("mid_release_rst", dut_out(), 7'b1111001);
    repeat (5) stepEdge();
    applyStimulus(1'b0, 1'b0);
    runTo(17);
    checkOutput("restart_e17", dut_out(), 7'b1111001);
    stepEdge();
    checkOutput("restart_e18", dut_out(), 7'b1110001);

    // randomized requests and reset pulses against the model
    rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rst_left > 0) begin
        rst_left = rst_left - 1;
        if (rst_left == 0) applyStimulus(1'b0, sw_req);
      end else if ($urandom_range(0, 599) == 0) begin
        applyStimulus(1'b1, sw_req);
        rst_left = $urandom_range(1, 4);
      end
      if (sw_req) sw_req = ($urandom_range(0, 19) != 0);
      else        sw_req = ($urandom_range(0, 29) == 0);
      stepEdge();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
